fwd_scoreboard: RTL and testbench

- Parametrised decode-stage forwarding and interlock unit for the in-order pipeline.
- Keeps a shadow tag pipeline of in-flight destination registers for NUM_STAGES post-decode stages, plus a fixed-latency multdiv tracker.
- Drives forwarded rs/rt operands into decode, and stalls decode on load-use, multdiv RAW/WAW and multdiv structural hazards.

---
 rtl/fwd_scoreboard.sv | 188 ++++++++++++++++++
 tb/tb_fwd_scoreboard.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fwd_scoreboard.sv
// Decode-stage forwarding and interlock unit.
// Tracks destination tags for the post-decode stages, picks the youngest
// producer for each decode source, and stalls decode on load-use and on
// hazards against the single in-flight fixed-latency multdiv operation.
//
// multdiv tracker states
//   state   | meaning
//   MD_IDLE | no multdiv in flight, a new one may issue
//   MD_RUN  | multdiv in flight, counting down to its writeback pulse
module fwd_scoreboard #(
  parameter int REG_BITS         = 5,
  parameter int DATA_W           = 32,
  parameter int NUM_STAGES       = 3,
  parameter int LOAD_READY_STAGE = 2,
  parameter int MD_CYCLES        = 33
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         issue_valid,
  input  logic                         issue_we,
  input  logic [REG_BITS-1:0]          issue_rd,
  input  logic                         issue_is_load,
  input  logic                         issue_is_md,
  input  logic [REG_BITS-1:0]          dec_rs,
  input  logic [REG_BITS-1:0]          dec_rt,
  input  logic                         dec_rs_used,
  input  logic                         dec_rt_used,
  input  logic [DATA_W-1:0]            rf_rs_data,
  input  logic [DATA_W-1:0]            rf_rt_data,
  input  logic [NUM_STAGES*DATA_W-1:0] stage_data,
  output logic [DATA_W-1:0]            fwd_rs_data,
  output logic [DATA_W-1:0]            fwd_rt_data,
  output logic [NUM_STAGES:0]          fwd_rs_sel,
  output logic [NUM_STAGES:0]          fwd_rt_sel,
  output logic                         stall,
  output logic                         md_busy,
  output logic                         md_wb,
  output logic [REG_BITS-1:0]          md_wb_rd
);

  localparam int SEL_W = NUM_STAGES + 1;
  localparam int CNT_W = (MD_CYCLES > 2) ? $clog2(MD_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MD_CYCLES - 1);

  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_RUN  = 1'b1
  } md_state_t;

  typedef struct packed {
    logic [SEL_W-1:0]  sel;
    logic [DATA_W-1:0] data;
    logic              load_wait;
  } fwd_t;

  // shadow tag pipeline, index 0 is the stage right after decode
  logic [NUM_STAGES-1:0]               tag_valid_q, tag_valid_d;
  logic [NUM_STAGES-1:0][REG_BITS-1:0] tag_rd_q, tag_rd_d;
  logic [NUM_STAGES-1:0]               tag_load_q, tag_load_d;

  // multdiv tracker
  md_state_t         md_state_q, md_state_d;
  logic [REG_BITS-1:0] md_rd_q, md_rd_d;
  logic [CNT_W-1:0]  md_cnt_q, md_cnt_d;

  logic md_pending;
  logic md_done;
  logic md_issue;
  logic md_raw_rs, md_raw_rt, md_waw, md_struct;
  logic md_stall;
  logic load_stall;
  fwd_t rs_fwd, rt_fwd;

  // Pick the youngest in-flight producer of src; an unused source or r0
  // reads as zero from the RF leg.  Scanning from the oldest stage down
  // lets the lowest matching index overwrite the result last.
  function automatic fwd_t pick_src(
    input logic [REG_BITS-1:0] src,
    input logic                used,
    input logic [DATA_W-1:0]   rf_data
  );
    fwd_t r;
    r            = '0;
    r.sel[NUM_STAGES] = 1'b1;
    if (used && (src != '0)) begin
      r.data = rf_data;
      for (int i = NUM_STAGES - 1; i >= 0; i--) begin
        if (tag_valid_q[i] && (tag_rd_q[i] == src)) begin
          r.sel       = '0;
          r.sel[i]    = 1'b1;
          r.data      = stage_data[i*DATA_W +: DATA_W];
          r.load_wait = tag_load_q[i] && (i < LOAD_READY_STAGE);
        end
      end
    end
    return r;
  endfunction

  // forwarding selection and load-use detection for both sources
  always_comb begin
    rs_fwd     = pick_src(dec_rs, dec_rs_used, rf_rs_data);
    rt_fwd     = pick_src(dec_rt, dec_rt_used, rf_rt_data);
    load_stall = rs_fwd.load_wait | rt_fwd.load_wait;
  end

  assign fwd_rs_data = rs_fwd.data;
  assign fwd_rs_sel  = rs_fwd.sel;
  assign fwd_rt_data = rt_fwd.data;
  assign fwd_rt_sel  = rt_fwd.sel;

  // multdiv hazards; r0 as a destination is never tracked
  always_comb begin
    md_pending = (md_state_q == MD_RUN);
    md_done    = md_pending && (md_cnt_q == '0);
    md_raw_rs  = dec_rs_used && (dec_rs != '0) && (dec_rs == md_rd_q);
    md_raw_rt  = dec_rt_used && (dec_rt != '0) && (dec_rt == md_rd_q);
    md_waw     = issue_valid && issue_we && (issue_rd == md_rd_q) && (md_rd_q != '0);
    md_struct  = issue_valid && issue_is_md;
    md_stall   = md_pending && (md_raw_rs || md_raw_rt || md_waw || md_struct);
    stall      = load_stall | md_stall;
    md_issue   = issue_valid && issue_is_md && !stall;
  end

  assign md_busy  = md_pending;
  assign md_wb    = md_done;
  assign md_wb_rd = md_rd_q;

  // tag shift: a stalled or multdiv instruction enters as a bubble
  always_comb begin
    tag_valid_d    = '0;
    tag_rd_d       = '0;
    tag_load_d     = '0;
    tag_valid_d[0] = issue_valid & issue_we & ~issue_is_md & ~stall;
    tag_rd_d[0]    = issue_rd;
    tag_load_d[0]  = issue_is_load;
    for (int i = 1; i < NUM_STAGES; i++) begin
      tag_valid_d[i] = tag_valid_q[i-1];
      tag_rd_d[i]    = tag_rd_q[i-1];
      tag_load_d[i]  = tag_load_q[i-1];
    end
  end

  // multdiv next-state: load on issue, count down, release after wb cycle
  always_comb begin
    md_state_d = md_state_q;
    md_rd_d    = md_rd_q;
    md_cnt_d   = md_cnt_q;
    unique case (md_state_q)
      MD_IDLE: begin
        if (md_issue) begin
          md_state_d = MD_RUN;
          md_rd_d    = issue_rd;
          md_cnt_d   = CNT_LOAD;
        end
      end
      MD_RUN: begin
        if (md_cnt_q == '0) begin
          md_state_d = MD_IDLE;
        end else begin
          md_cnt_d = md_cnt_q - CNT_W'(1);
        end
      end
      default: begin
        md_state_d = MD_IDLE;
      end
    endcase
  end

  // state registers; stalls never freeze the tag pipeline or the counter
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      tag_valid_q <= '0;
      tag_rd_q    <= '0;
      tag_load_q  <= '0;
      md_state_q  <= MD_IDLE;
      md_rd_q     <= '0;
      md_cnt_q    <= '0;
    end else begin
      tag_valid_q <= tag_valid_d;
      tag_rd_q    <= tag_rd_d;
      tag_load_q  <= tag_load_d;
      md_state_q  <= md_state_d;
      md_rd_q     <= md_rd_d;
      md_cnt_q    <= md_cnt_d;
    end
  end

endmodule

// File: tb/tb_fwd_scoreboard.sv
// Directed bench for fwd_scoreboard: per-cycle expectations are queued as
// stimulus is driven and compared at the falling edge; multdiv writebacks
// are queued with their due cycle and matched against md_wb.
module tb_fwd_scoreboard;

  localparam int REG_BITS = 5;
  localparam int DATA_W   = 32;
  localparam int NS       = 3;
  localparam int MD       = 33;

  localparam logic [31:0] SD0 = 32'h0000_1234;
  localparam logic [31:0] SD1 = 32'h2222_2222;
  localparam logic [31:0] SD2 = 32'h3333_3333;
  localparam logic [31:0] RFS = 32'h5555_5555;
  localparam logic [31:0] RFT = 32'h6666_6666;
  localparam logic [3:0]  SEL0  = 4'b0001;
  localparam logic [3:0]  SEL1  = 4'b0010;
  localparam logic [3:0]  SEL2  = 4'b0100;
  localparam logic [3:0]  SELRF = 4'b1000;

  logic                    clock;
  logic                    reset;
  logic                    issue_valid, issue_we, issue_is_load, issue_is_md;
  logic [REG_BITS-1:0]     issue_rd, dec_rs, dec_rt;
  logic                    dec_rs_used, dec_rt_used;
  logic [DATA_W-1:0]       rf_rs_data, rf_rt_data;
  logic [NS*DATA_W-1:0]    stage_data;
  logic [DATA_W-1:0]       fwd_rs_data, fwd_rt_data;
  logic [NS:0]             fwd_rs_sel, fwd_rt_sel;
  logic                    stall, md_busy, md_wb;
  logic [REG_BITS-1:0]     md_wb_rd;

  fwd_scoreboard #(
    .REG_BITS(REG_BITS), .DATA_W(DATA_W), .NUM_STAGES(NS),
    .LOAD_READY_STAGE(2), .MD_CYCLES(MD)
  ) dut (
    .clock(clock), .reset(reset),
    .issue_valid(issue_valid), .issue_we(issue_we), .issue_rd(issue_rd),
    .issue_is_load(issue_is_load), .issue_is_md(issue_is_md),
    .dec_rs(dec_rs), .dec_rt(dec_rt),
    .dec_rs_used(dec_rs_used), .dec_rt_used(dec_rt_used),
    .rf_rs_data(rf_rs_data), .rf_rt_data(rf_rt_data),
    .stage_data(stage_data),
    .fwd_rs_data(fwd_rs_data), .fwd_rt_data(fwd_rt_data),
    .fwd_rs_sel(fwd_rs_sel), .fwd_rt_sel(fwd_rt_sel),
    .stall(stall), .md_busy(md_busy), .md_wb(md_wb), .md_wb_rd(md_wb_rd)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef enum {K_RS_SEL, K_RS_DATA, K_RT_SEL, K_RT_DATA, K_STALL, K_BUSY} kind_t;
  typedef struct {
    kind_t       kind;
    string       tag;
    logic [31:0] val;
  } exp_t;
  typedef struct {
    int                  due;
    logic [REG_BITS-1:0] rd;
  } wb_t;

  exp_t exp_q[$];
  wb_t  wb_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   md2_start = 0;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  task automatic expect_out(input kind_t k, input string tag, input logic [31:0] v);
    exp_t e;
    e.kind = k;
    e.tag  = tag;
    e.val  = v;
    exp_q.push_back(e);
  endtask

  task automatic expect_rs(input string tag, input logic [3:0] sel, input logic [31:0] data);
    expect_out(K_RS_SEL, {tag, "_rs_sel"}, 32'(sel));
    expect_out(K_RS_DATA, {tag, "_rs_data"}, data);
  endtask

  task automatic expect_rt(input string tag, input logic [3:0] sel, input logic [31:0] data);
    expect_out(K_RT_SEL, {tag, "_rt_sel"}, 32'(sel));
    expect_out(K_RT_DATA, {tag, "_rt_data"}, data);
  endtask

  task automatic expect_wb(input logic [REG_BITS-1:0] rd);
    wb_t w;
    w.due = cyc + MD;
    w.rd  = rd;
    wb_q.push_back(w);
  endtask

  task automatic compare_outputs();
    exp_t        e;
    logic [31:0] act;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      case (e.kind)
        K_RS_SEL:  act = 32'(fwd_rs_sel);
        K_RS_DATA: act = fwd_rs_data;
        K_RT_SEL:  act = 32'(fwd_rt_sel);
        K_RT_DATA: act = fwd_rt_data;
        K_STALL:   act = 32'(stall);
        default:   act = 32'(md_busy);
      endcase
      check_val(e.tag, act, e.val);
    end
  endtask

  task automatic check_wb();
    wb_t w;
    if (wb_q.size() > 0 && wb_q[0].due == cyc) begin
      w = wb_q.pop_front();
      check_val("md_wb", 32'(md_wb), 32'd1);
      check_val("md_wb_rd", 32'(md_wb_rd), 32'(w.rd));
    end else begin
      check_val("md_wb_idle", 32'(md_wb), 32'd0);
    end
  endtask

  task automatic tick();
    @(negedge clock);
    compare_outputs();
    check_wb();
    @(posedge clock);
    #1;
    cyc++;
  endtask

  task automatic drive_idle();
    issue_valid   = 1'b0;
    issue_we      = 1'b0;
    issue_rd      = '0;
    issue_is_load = 1'b0;
    issue_is_md   = 1'b0;
    dec_rs        = '0;
    dec_rs_used   = 1'b0;
    dec_rt        = '0;
    dec_rt_used   = 1'b0;
  endtask

  task automatic drive_issue(input logic we, input logic [REG_BITS-1:0] rd,
                             input logic ld, input logic md);
    issue_valid   = 1'b1;
    issue_we      = we;
    issue_rd      = rd;
    issue_is_load = ld;
    issue_is_md   = md;
  endtask

  task automatic read_rs(input logic [REG_BITS-1:0] r);
    dec_rs      = r;
    dec_rs_used = 1'b1;
  endtask

  task automatic read_rt(input logic [REG_BITS-1:0] r);
    dec_rt      = r;
    dec_rt_used = 1'b1;
  endtask

  initial begin
    reset      = 1'b0;
    stage_data = {SD2, SD1, SD0};
    rf_rs_data = RFS;
    rf_rt_data = RFT;
    drive_idle();
    #1 reset = 1'b1;

    // reset state
    read_rs(5'd3);
    expect_rs("rst", SELRF, RFS);
    expect_rt("rst", SELRF, 32'd0);
    expect_out(K_STALL, "rst_stall", 32'd0);
    expect_out(K_BUSY, "rst_busy", 32'd0);
    tick();
    reset = 1'b0;

    // back-to-back dependency on r3 walking down the stages
    drive_idle(); drive_issue(1'b1, 5'd3, 1'b0, 1'b0);
    expect_out(K_STALL, "b2b_issue_stall", 32'd0);
    tick();
    drive_idle(); read_rs(5'd3);
    expect_rs("b2b_x", SEL0, SD0); expect_out(K_STALL, "b2b_x_stall", 32'd0);
    tick();
    drive_idle(); read_rs(5'd3);
    expect_rs("b2b_m", SEL1, SD1);
    tick();
    drive_idle(); read_rs(5'd3);
    expect_rs("b2b_w", SEL2, SD2);
    tick();
    drive_idle(); read_rs(5'd3);
    expect_rs("b2b_rf", SELRF, RFS);
    tick();

    // priority: r5 in stages 0 and 2, r9 in stage 1
    drive_idle(); drive_issue(1'b1, 5'd5, 1'b0, 1'b0); tick();
    drive_idle(); drive_issue(1'b1, 5'd9, 1'b0, 1'b0); tick();
    drive_idle(); drive_issue(1'b1, 5'd5, 1'b0, 1'b0); tick();
    drive_idle(); read_rt(5'd5); read_rs(5'd9);
    expect_rt("prio_s0", SEL0, SD0);
    expect_rs("prio_r9", SEL1, SD1);
    tick();
    drive_idle(); read_rt(5'd5);
    expect_rt("prio_s1", SEL1, SD1);
    tick();
    // r5 alone in stage 2 with stages 0 and 1 empty
    drive_idle(); drive_issue(1'b1, 5'd5, 1'b0, 1'b0); tick();
    drive_idle(); tick();
    drive_idle(); tick();
    drive_idle(); read_rt(5'd5);
    expect_rt("prio_s2_only", SEL2, SD2);
    tick();

    // load-use: lw r4 then a consumer writing r6
    drive_idle(); drive_issue(1'b1, 5'd4, 1'b1, 1'b0);
    expect_out(K_STALL, "lu_lw_stall", 32'd0);
    tick();
    drive_idle(); drive_issue(1'b1, 5'd6, 1'b0, 1'b0); read_rs(5'd4); read_rt(5'd6);
    expect_out(K_STALL, "lu_c1_stall", 32'd1);
    expect_rs("lu_c1", SEL0, SD0); expect_rt("lu_c1", SELRF, RFT);
    tick();
    drive_idle(); drive_issue(1'b1, 5'd6, 1'b0, 1'b0); read_rs(5'd4); read_rt(5'd6);
    expect_out(K_STALL, "lu_c2_stall", 32'd1);
    expect_rs("lu_c2", SEL1, SD1); expect_rt("lu_c2", SELRF, RFT);
    tick();
    drive_idle(); drive_issue(1'b1, 5'd6, 1'b0, 1'b0); read_rs(5'd4); read_rt(5'd6);
    expect_out(K_STALL, "lu_c3_stall", 32'd0);
    expect_rs("lu_c3", SEL2, SD2); expect_rt("lu_bubble", SELRF, RFT);
    tick();
    drive_idle(); read_rt(5'd6);
    expect_rt("lu_after", SEL0, SD0); expect_out(K_STALL, "lu_after_stall", 32'd0);
    tick();
    // a younger ALU write of r8 hides the older load of r8
    drive_idle(); drive_issue(1'b1, 5'd8, 1'b1, 1'b0); tick();
    drive_idle(); drive_issue(1'b1, 5'd8, 1'b0, 1'b0);
    expect_out(K_STALL, "shadow_issue_stall", 32'd0);
    tick();
    drive_idle(); read_rs(5'd8);
    expect_rs("shadow", SEL0, SD0); expect_out(K_STALL, "shadow_stall", 32'd0);
    tick();

    // register zero and unused sources
    drive_idle(); drive_issue(1'b1, 5'd0, 1'b1, 1'b0); tick();
    drive_idle(); read_rs(5'd0); read_rt(5'd0);
    expect_rs("r0", SELRF, 32'd0); expect_rt("r0", SELRF, 32'd0);
    expect_out(K_STALL, "r0_stall", 32'd0);
    tick();
    drive_idle(); drive_issue(1'b1, 5'd3, 1'b0, 1'b0); tick();
    drive_idle(); dec_rs = 5'd3; dec_rs_used = 1'b0;
    expect_rs("unused", SELRF, 32'd0);
    tick();

    // multdiv r7, then mult r11 that reads r7 (RAW + structural)
    drive_idle(); drive_issue(1'b1, 5'd7, 1'b0, 1'b1);
    expect_out(K_STALL, "md_issue_stall", 32'd0);
    expect_out(K_BUSY, "md_issue_busy", 32'd0);
    expect_wb(5'd7);
    tick();
    for (int k = 1; k <= MD; k++) begin
      drive_idle(); drive_issue(1'b1, 5'd11, 1'b0, 1'b1); read_rs(5'd7);
      expect_out(K_STALL, "md_wait_stall", 32'd1);
      expect_out(K_BUSY, "md_wait_busy", 32'd1);
      tick();
    end
    drive_idle(); drive_issue(1'b1, 5'd11, 1'b0, 1'b1); read_rs(5'd7);
    expect_out(K_STALL, "md_proceed_stall", 32'd0);
    expect_out(K_BUSY, "md_proceed_busy", 32'd0);
    expect_rs("md_proceed", SELRF, RFS);
    expect_wb(5'd11);
    md2_start = cyc;
    tick();
    drive_idle(); drive_issue(1'b1, 5'd11, 1'b0, 1'b0);
    expect_out(K_STALL, "md_waw_stall", 32'd1);
    tick();
    drive_idle(); drive_issue(1'b1, 5'd12, 1'b0, 1'b0);
    expect_out(K_STALL, "md_nodep_stall", 32'd0);
    tick();
    drive_idle(); read_rs(5'd12); read_rt(5'd11);
    expect_rs("md_fwd_while_busy", SEL0, SD0);
    expect_out(K_STALL, "md_raw_rt_stall", 32'd1);
    tick();
    while (cyc < md2_start + 10) begin
      drive_idle();
      expect_out(K_BUSY, "md2_busy", 32'd1);
      tick();
    end

    // asynchronous reset in the middle of the second multdiv
    drive_idle(); drive_issue(1'b1, 5'd11, 1'b0, 1'b1);
    #2;
    check_val("pre_rst_stall", 32'(stall), 32'd1);
    reset = 1'b1;
    #1;
    check_val("async_rst_busy", 32'(md_busy), 32'd0);
    check_val("async_rst_stall", 32'(stall), 32'd0);
    wb_q.delete();
    expect_out(K_STALL, "rst_hold_stall", 32'd0);
    expect_out(K_BUSY, "rst_hold_busy", 32'd0);
    tick();
    drive_idle();
    reset = 1'b0;
    for (int k = 0; k < 40; k++) begin
      drive_idle();
      expect_out(K_BUSY, "post_rst_busy", 32'd0);
      tick();
    end

    // multdiv to r0: no dependency tracking, writeback still pulses
    drive_idle(); drive_issue(1'b1, 5'd0, 1'b0, 1'b1);
    expect_out(K_STALL, "md0_issue_stall", 32'd0);
    expect_wb(5'd0);
    tick();
    for (int k = 1; k <= MD; k++) begin
      drive_idle(); drive_issue(1'b1, 5'd0, 1'b0, 1'b0); read_rs(5'd0);
      expect_out(K_STALL, "md0_stall", 32'd0);
      expect_out(K_BUSY, "md0_busy", 32'd1);
      expect_rs("md0", SELRF, 32'd0);
      tick();
    end
    drive_idle();
    expect_out(K_BUSY, "md0_done_busy", 32'd0);
    tick();

    check_val("wb_drain", 32'(wb_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
